// File: rtl/gpio_serial_loader_if.sv
// Request/status and serial-chain signals of the GPIO configuration loader.
// The slave modport is the loader itself; the master modport is its requester and chain.
interface gpio_serial_loader_if #(
    parameter int NUM_GPIO  = 19,
    parameter int CFG_WIDTH = 13
);
    logic                            start;
    logic [NUM_GPIO*CFG_WIDTH-1:0]   cfg_data;
    logic                            busy;
    logic                            done;
    logic                            serial_clock;
    logic                            serial_data;
    logic                            serial_load;
    logic                            serial_resetn;

    modport master (
        output start, cfg_data,
        input  busy, done, serial_clock, serial_data, serial_load, serial_resetn
    );

    modport slave (
        input  start, cfg_data,
        output busy, done, serial_clock, serial_data, serial_load, serial_resetn
    );
endinterface

// File: rtl/gpio_serial_loader.sv
// Transmit end of the GPIO configuration shift chain: serialises one word per pad,
// farthest pad first and MSB first, then strobes serial_load.
module gpio_serial_loader #(
    parameter int NUM_GPIO  = 19,
    parameter int CFG_WIDTH = 13,
    parameter int CLK_DIV   = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    gpio_serial_loader_if.slave   ser
);
    localparam int TOTAL = NUM_GPIO * CFG_WIDTH;
    localparam int BCW   = $clog2(TOTAL + 1);
    localparam logic [7:0]     PH_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [BCW-1:0] BC_LOAD   = BCW'(TOTAL);
    localparam logic [BCW-1:0] BC_LAST   = BCW'(1);

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, GUARD, LOAD} state_e;

    state_e             state_q, state_d;
    logic [7:0]         phase_q, phase_d;
    logic [BCW-1:0]     bitcnt_q, bitcnt_d;
    logic [TOTAL-1:0]   shadow_q, shadow_d;
    logic               sclk_q, sclk_d;
    logic               sload_q, sload_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               resetn_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            bitcnt_q <= '0;
            shadow_q <= '0;
            sclk_q   <= 1'b0;
            sload_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            resetn_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bitcnt_q <= bitcnt_d;
            shadow_q <= shadow_d;
            sclk_q   <= sclk_d;
            sload_q  <= sload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            resetn_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bitcnt_d = bitcnt_q;
        shadow_d = shadow_q;
        sclk_d   = sclk_q;
        sload_d  = sload_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ser.start) begin
                    shadow_d = ser.cfg_data;
                    bitcnt_d = BC_LOAD;
                    phase_d  = PH_RELOAD;
                    sclk_d   = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_q == 8'd0) begin
                    phase_d = PH_RELOAD;
                    sclk_d  = 1'b1;
                    state_d = SHIFT_HI;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            SHIFT_HI: begin
                if (phase_q == 8'd0) begin
                    phase_d  = PH_RELOAD;
                    sclk_d   = 1'b0;
                    bitcnt_d = bitcnt_q - BC_LAST;
                    // Zeros shift in behind the data, so after the last bit the
                    // MSB (serial_data) is already 0 for the guard phase.
                    shadow_d = {shadow_q[TOTAL-2:0], 1'b0};
                    state_d  = (bitcnt_q != BC_LAST) ? SHIFT_LO : GUARD;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            GUARD: begin
                if (phase_q == 8'd0) begin
                    phase_d = PH_RELOAD;
                    sload_d = 1'b1;
                    state_d = LOAD;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            LOAD: begin
                if (phase_q == 8'd0) begin
                    sload_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ser.busy          = busy_q;
    assign ser.done          = done_q;
    assign ser.serial_clock  = sclk_q;
    assign ser.serial_data   = shadow_q[TOTAL-1];
    assign ser.serial_load   = sload_q;
    assign ser.serial_resetn = resetn_q;
endmodule

// File: tb/tb_gpio_serial_loader.sv
// Randomised bench: two loaders (2 pads/CLK_DIV=2 and 1 pad/CLK_DIV=1) feed a
// behavioural chain of 13-bit receivers; words, timing and strobes are checked.
module tb_gpio_serial_loader;
    localparam int CD  [2] = '{2, 1};
    localparam int TOT [2] = '{26, 13};
    localparam logic [25:0] DEF  = {13'h0402, 13'h0402};
    localparam logic [25:0] SPEC = {13'h1803, 13'h0402};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0]  start_r = '0;
    logic [25:0] cfg_r [2];

    gpio_serial_loader_if #(.NUM_GPIO(2), .CFG_WIDTH(13)) ifa ();
    gpio_serial_loader_if #(.NUM_GPIO(1), .CFG_WIDTH(13)) ifb ();

    assign ifa.start    = start_r[0];
    assign ifa.cfg_data = cfg_r[0];
    assign ifb.start    = start_r[1];
    assign ifb.cfg_data = cfg_r[1][12:0];

    gpio_serial_loader #(.NUM_GPIO(2), .CFG_WIDTH(13), .CLK_DIV(2)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .ser(ifa));
    gpio_serial_loader #(.NUM_GPIO(1), .CFG_WIDTH(13), .CLK_DIV(1)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .ser(ifb));

    always #5 clk = ~clk;

    logic [1:0] busy, done, sclk, sdat, sload, srst;
    assign busy  = {ifb.busy, ifa.busy};
    assign done  = {ifb.done, ifa.done};
    assign sclk  = {ifb.serial_clock, ifa.serial_clock};
    assign sdat  = {ifb.serial_data, ifa.serial_data};
    assign sload = {ifb.serial_load, ifa.serial_load};
    assign srst  = {ifb.serial_resetn, ifa.serial_resetn};

    // Behavioural chain: shift register clocked by serial_clock rises,
    // receivers latched on serial_load, defaulted while serial_resetn is low.
    logic [25:0] sr [2], rx [2], rxpre [2];
    logic [1:0]  psc = '0, psl = '0, hd = '0;
    int nb [2], bc [2], lc [2], dc [2], hv [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (sclk[d] && !psc[d]) begin
                sr[d] = {sr[d][24:0], sdat[d]};
                nb[d]++;
                hd[d] = sdat[d];
            end else if (sclk[d] && psc[d] && sdat[d] != hd[d]) begin
                hv[d]++;
            end
            if (busy[d])  bc[d]++;
            if (sload[d]) lc[d]++;
            if (done[d])  dc[d]++;
            if (sload[d] && !psl[d]) begin
                rxpre[d] = rx[d];
                rx[d]    = sr[d];
            end
            if (!srst[d]) rx[d] = DEF;
            psc[d] = sclk[d];
            psl[d] = sload[d];
        end
    end

    int ntest = 0, nfail = 0;
    int s_nb, s_bc, s_lc, s_dc, s_hv;
    logic [25:0] exp_rx [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntest++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] msk(input int d);
        return (d == 0) ? 26'h3ffffff : 26'h0001fff;
    endfunction

    task automatic snap(input int d);
        s_nb = nb[d]; s_bc = bc[d]; s_lc = lc[d]; s_dc = dc[d]; s_hv = hv[d];
    endtask

    // Called at negedge+1; start is sampled on the following posedge.
    task automatic kick(input int d, input logic [25:0] w);
        snap(d);
        cfg_r[d] = w;
        start_r[d] = 1'b1;
        @(negedge clk); #1;
        start_r[d] = 1'b0;
        chk("busy_after_start", 64'(busy[d]), 64'd1);
    endtask

    task automatic finish(input int d, input logic [25:0] w, input bit nxt, input logic [25:0] nw);
        bit ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (done[d]) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        chk("done_seen", 64'(ok), 64'd1);
        chk("busy_low_at_done", 64'(busy[d]), 64'd0);
        chk("shifted_bits", 64'(sr[d] & msk(d)), 64'(w & msk(d)));
        chk("rise_count", 64'(nb[d] - s_nb), 64'(TOT[d]));
        chk("busy_cycles", 64'(bc[d] - s_bc), 64'(2 * CD[d] * TOT[d] + 2 * CD[d]));
        chk("load_cycles", 64'(lc[d] - s_lc), 64'(CD[d]));
        chk("done_pulses", 64'(dc[d] - s_dc), 64'd1);
        chk("data_stable_high", 64'(hv[d] - s_hv), 64'd0);
        chk("rx_before_load", 64'(rxpre[d] & msk(d)), 64'(exp_rx[d]));
        chk("rx_after_load", 64'(rx[d] & msk(d)), 64'(w & msk(d)));
        exp_rx[d] = w & msk(d);
        if (nxt) begin
            cfg_r[d] = nw;
            start_r[d] = 1'b1;
            snap(d);
            @(negedge clk); #1;
            start_r[d] = 1'b0;
            chk("b2b_no_gap", 64'(busy[d]), 64'd1);
        end
    endtask

    task automatic chk_all_reset(input int d);
        chk("rst_busy", 64'(busy[d]), 64'd0);
        chk("rst_done", 64'(done[d]), 64'd0);
        chk("rst_sclk", 64'(sclk[d]), 64'd0);
        chk("rst_sdata", 64'(sdat[d]), 64'd0);
        chk("rst_sload", 64'(sload[d]), 64'd0);
        chk("rst_sresetn", 64'(srst[d]), 64'd0);
    endtask

    initial begin
        logic [25:0] w0, w1, w2;
        bit ok;
        cfg_r[0] = '0;
        cfg_r[1] = '0;
        #1;
        chk_all_reset(0);
        chk_all_reset(1);
        @(negedge clk); #1;
        rst = 1'b0;
        chk("resetn_before_edge", 64'(srst[0]), 64'd0);
        @(negedge clk); #1;
        chk("resetn_after_edge", 64'(srst), 64'd3);
        exp_rx[0] = DEF & msk(0);
        exp_rx[1] = DEF & msk(1);

        // Reference transfer and all-ones single-pad transfer
        kick(0, SPEC);
        finish(0, SPEC, 1'b0, '0);
        kick(1, 26'h0001fff);
        finish(1, 26'h0001fff, 1'b0, '0);

        // Random back-to-back chain, new start issued on each done cycle
        w0 = 26'($urandom); w1 = 26'($urandom); w2 = 26'($urandom);
        kick(0, w0);
        finish(0, w0, 1'b1, w1);
        finish(0, w1, 1'b1, w2);
        finish(0, w2, 1'b0, '0);
        for (int i = 0; i < 2; i++) begin
            w0 = 26'($urandom);
            kick(1, w0);
            finish(1, w0, 1'b0, '0);
        end

        // Start and cfg_data disturbed mid-transfer
        w0 = 26'($urandom);
        kick(0, w0);
        repeat (20) @(negedge clk);
        #1;
        cfg_r[0] = ~w0;
        start_r[0] = 1'b1;
        @(negedge clk); #1;
        start_r[0] = 1'b0;
        finish(0, w0, 1'b0, '0);
        snap(0);
        repeat (150) @(negedge clk);
        #1;
        chk("no_queued_start", 64'(bc[0] - s_bc), 64'd0);

        // Asynchronous reset during bit 10
        w0 = 26'($urandom);
        kick(0, w0);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (nb[0] - s_nb >= 10) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        chk("reached_bit10", 64'(ok), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_reset(0);
        @(negedge clk); #1;
        rst = 1'b0;
        chk("no_done_on_abort", 64'(dc[0] - s_dc), 64'd0);
        chk("chain_defaulted", 64'(rx[0]), 64'(DEF));
        exp_rx[0] = DEF & msk(0);
        exp_rx[1] = DEF & msk(1);
        @(negedge clk); #1;
        chk("resetn_after_abort", 64'(srst[0]), 64'd1);
        w0 = 26'($urandom);
        kick(0, w0);
        finish(0, w0, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
